// File: rtl/icache_pkg.sv
// Shared types for the instruction cache: address overlay, frame layout, FSM states.
package icache_pkg;

  typedef logic [31:0] word_t;

  localparam int unsigned ICACHE_SETS = 16;

  typedef struct packed {
    logic [25:0] tag;
    logic [3:0]  idx;
    logic [1:0]  bytoff;
  } icachef_t;

  typedef struct packed {
    logic        valid;
    logic [25:0] tag;
    word_t       data;
  } icache_frame_t;

  typedef enum logic {
    IDLE,
    FETCH
  } icache_state_t;

endpackage

// File: rtl/icache_if.sv
// Datapath-to-cache fetch port and cache-to-memory-controller read port.
interface datapath_cache_if;
  import icache_pkg::*;

  logic  imemREN;
  word_t imemaddr;
  logic  ihit;
  word_t imemload;

  modport master (output imemREN, imemaddr, input ihit, imemload);
  modport slave  (input imemREN, imemaddr, output ihit, imemload);
endinterface

interface caches_if;
  import icache_pkg::*;

  logic  iREN;
  word_t iaddr;
  logic  iwait;
  word_t iload;

  modport master (output iREN, iaddr, input iwait, iload);
  modport slave  (input iREN, iaddr, output iwait, iload);
endinterface

// File: rtl/icache_frames.sv
// Valid/tag/data frame array: combinational read, synchronous write, async valid clear.
module icache_frames
  import icache_pkg::*;
#(
  parameter int unsigned SETS  = ICACHE_SETS,
  parameter int unsigned IDX_W = $clog2(SETS),
  parameter int unsigned TAG_W = 30 - IDX_W
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic             rd_valid_o,
  output logic [TAG_W-1:0] rd_tag_o,
  output word_t            rd_data_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [TAG_W-1:0] wr_tag_i,
  input  word_t            wr_data_i
);

  logic [SETS-1:0]  valid_q;
  logic [TAG_W-1:0] tag_q  [SETS];
  word_t            data_q [SETS];

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  // Tag/data need no reset: they are only observed through a set valid bit.
  always_ff @(posedge CLK) begin
    if (wr_en_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

  always_comb begin
    rd_valid_o = valid_q[rd_idx_i];
    rd_tag_o   = tag_q[rd_idx_i];
    rd_data_o  = data_q[rd_idx_i];
  end

endmodule

// File: rtl/icache.sv
// Direct-mapped, one-word-block instruction cache: same-cycle hits, blocking miss fill.
module icache
  import icache_pkg::*;
#(
  parameter int unsigned SETS = ICACHE_SETS
) (
  input  logic           CLK,
  input  logic           nRST,
  datapath_cache_if.slave dcif,
  caches_if.master        cif
);

  localparam int unsigned IDX_W = $clog2(SETS);
  localparam int unsigned TAG_W = 30 - IDX_W;

  icache_state_t    state_q, state_d;
  word_t            miss_addr_q, miss_addr_d;
  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic [TAG_W-1:0] req_tag, rd_tag, miss_tag;
  logic             rd_valid, hit, fill;
  word_t            rd_data;

  assign rd_idx   = dcif.imemaddr[2 +: IDX_W];
  assign req_tag  = dcif.imemaddr[31 -: TAG_W];
  assign wr_idx   = miss_addr_q[2 +: IDX_W];
  assign miss_tag = miss_addr_q[31 -: TAG_W];
  assign hit      = dcif.imemREN && (state_q == IDLE) && rd_valid && (rd_tag == req_tag);

  icache_frames #(
    .SETS  (SETS),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_frames (
    .CLK        (CLK),
    .nRST       (nRST),
    .rd_idx_i   (rd_idx),
    .rd_valid_o (rd_valid),
    .rd_tag_o   (rd_tag),
    .rd_data_o  (rd_data),
    .wr_en_i    (fill),
    .wr_idx_i   (wr_idx),
    .wr_tag_i   (miss_tag),
    .wr_data_i  (cif.iload)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      miss_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    unique case (state_q)
      IDLE: begin
        if (dcif.imemREN && !hit) begin
          state_d     = FETCH;
          miss_addr_d = dcif.imemaddr & 32'hFFFF_FFFC;
        end
      end
      FETCH: begin
        if (!cif.iwait) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The fill word is not forwarded; the requester hits on the following IDLE cycle.
  always_comb begin
    dcif.ihit     = hit;
    dcif.imemload = hit ? rd_data : '0;
    cif.iREN      = (state_q == FETCH);
    cif.iaddr     = miss_addr_q;
    fill          = (state_q == FETCH) && !cif.iwait;
  end

endmodule
